// File: rtl/itlb_miss_handler.sv
// Single-level page-table walker that refills the instruction TLB on a miss.
// Reads one PTE, then either strobes a refill or raises a held page fault.
module itlb_miss_handler #(
  parameter int VIRT_ADDR_WIDTH    = 32,
  parameter int PAGE_OFFSET_WIDTH  = 12,
  parameter int PHY_PAGE_NUM_WIDTH = 8,
  parameter int PHY_ADDR_WIDTH     = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [VIRT_ADDR_WIDTH-1:0]    VirtualAddr,
  input  logic                          tlb_miss,
  input  logic [PHY_ADDR_WIDTH-1:0]     ptbr,
  output logic                          mem_req,
  output logic [PHY_ADDR_WIDTH-1:0]     mem_addr,
  input  logic                          mem_ready,
  input  logic [31:0]                   mem_rdata,
  output logic                          tlb_write,
  output logic [PHY_PAGE_NUM_WIDTH-1:0] physical_page_num_mem,
  output logic                          page_fault,
  output logic [VIRT_ADDR_WIDTH-1:0]    fault_vaddr,
  input  logic                          fault_ack,
  output logic                          itlb_stall
);

  localparam int VPN_WIDTH = VIRT_ADDR_WIDTH - PAGE_OFFSET_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ, FILL, SETTLE, FAULT} state_t;

  state_t                      state;
  logic [VIRT_ADDR_WIDTH-1:0]  vaddr_q;
  logic [VPN_WIDTH-1:0]        vpn;
  logic [PHY_ADDR_WIDTH-1:0]   pte_addr;
  logic                        unused_pte_bits;

  // PTE address is word indexed from the table base; carries out of the top simply wrap.
  assign vpn             = VirtualAddr[VIRT_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
  assign pte_addr        = ptbr + PHY_ADDR_WIDTH'({vpn, 2'b00});
  assign unused_pte_bits = ^mem_rdata[30:PHY_PAGE_NUM_WIDTH];

  assign itlb_stall = (state != IDLE) | tlb_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      vaddr_q               <= '0;
      mem_req               <= 1'b0;
      mem_addr              <= '0;
      tlb_write             <= 1'b0;
      physical_page_num_mem <= '0;
      page_fault            <= 1'b0;
      fault_vaddr           <= '0;
    end else begin
      tlb_write <= 1'b0;
      case (state)
        IDLE: begin
          if (tlb_miss) begin
            vaddr_q  <= VirtualAddr;
            mem_addr <= pte_addr;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_rdata[31]) begin
              physical_page_num_mem <= mem_rdata[PHY_PAGE_NUM_WIDTH-1:0];
              tlb_write             <= 1'b1;
              state                 <= FILL;
            end else begin
              page_fault  <= 1'b1;
              fault_vaddr <= vaddr_q;
              state       <= FAULT;
            end
          end
        end
        FILL:   state <= SETTLE;
        // Gives the iTLB a cycle to drop tlb_miss so the same miss is not walked twice.
        SETTLE: state <= IDLE;
        FAULT: begin
          if (fault_ack) begin
            page_fault <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_miss_handler.sv
// Directed testbench for itlb_miss_handler with hand-computed expected values.
module tb_itlb_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] virtual_addr;
  logic        tlb_miss;
  logic [19:0] ptbr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [7:0]  physical_page_num_mem;
  logic        page_fault;
  logic [31:0] fault_vaddr;
  logic        fault_ack;
  logic        itlb_stall;

  int vectorCount = 0;
  int missCount   = 0;

  itlb_miss_handler dut (
    .clk                   (clk),
    .reset                 (reset),
    .VirtualAddr           (virtual_addr),
    .tlb_miss              (tlb_miss),
    .ptbr                  (ptbr),
    .mem_req               (mem_req),
    .mem_addr              (mem_addr),
    .mem_ready             (mem_ready),
    .mem_rdata             (mem_rdata),
    .tlb_write             (tlb_write),
    .physical_page_num_mem (physical_page_num_mem),
    .page_fault            (page_fault),
    .fault_vaddr           (fault_vaddr),
    .fault_ack             (fault_ack),
    .itlb_stall            (itlb_stall)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] base, input logic [31:0] va);
    ptbr         = base;
    virtual_addr = va;
    tlb_miss     = 1'b1;
  endtask

  initial begin
    reset = 1'b1; virtual_addr = '0; tlb_miss = 1'b0; ptbr = '0;
    mem_ready = 1'b0; mem_rdata = '0; fault_ack = 1'b0;
    tick(); tick();

    checkOutput("rst_mem_req",  32'(mem_req), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_tlb_wr",   32'(tlb_write), 32'h0);
    checkOutput("rst_ppn",      32'(physical_page_num_mem), 32'h0);
    checkOutput("rst_fault",    32'(page_fault), 32'h0);
    checkOutput("rst_fvaddr",   fault_vaddr, 32'h0);
    checkOutput("rst_stall0",   32'(itlb_stall), 32'h0);
    tlb_miss = 1'b1; #1;
    checkOutput("rst_stall1",   32'(itlb_stall), 32'h1);
    tick();
    checkOutput("rst_hold_req", 32'(mem_req), 32'h0);
    reset = 1'b0; tlb_miss = 1'b0;
    tick();

    // Basic refill, 3 cycles of memory latency
    applyStimulus(20'h01000, 32'h0021_0101); #1;
    checkOutput("b_stall_miss", 32'(itlb_stall), 32'h1);
    tick();
    checkOutput("b_mem_req",  32'(mem_req), 32'h1);
    checkOutput("b_mem_addr", 32'(mem_addr), 32'h01840);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("b_req_hold", 32'(mem_req), 32'h1);
      checkOutput("b_addr_hold", 32'(mem_addr), 32'h01840);
      checkOutput("b_stall_req", 32'(itlb_stall), 32'h1);
    end
    mem_ready = 1'b1; mem_rdata = 32'h8000_0011;
    tick();
    checkOutput("b_tlb_write", 32'(tlb_write), 32'h1);
    checkOutput("b_ppn",       32'(physical_page_num_mem), 32'h11);
    checkOutput("b_req_drop",  32'(mem_req), 32'h0);
    mem_ready = 1'b0; tlb_miss = 1'b0;
    tick();
    checkOutput("b_settle_wr",    32'(tlb_write), 32'h0);
    checkOutput("b_settle_stall", 32'(itlb_stall), 32'h1);
    tick();
    checkOutput("b_idle_stall", 32'(itlb_stall), 32'h0);
    checkOutput("b_idle_wr",    32'(tlb_write), 32'h0);
    checkOutput("b_ppn_hold",   32'(physical_page_num_mem), 32'h11);

    // mem_ready while idle must not cause a refill
    mem_ready = 1'b1; mem_rdata = 32'h8000_00EE;
    tick();
    checkOutput("idle_ready_wr",  32'(tlb_write), 32'h0);
    checkOutput("idle_ready_req", 32'(mem_req), 32'h0);
    mem_ready = 1'b0;

    // Zero-latency memory
    applyStimulus(20'h01000, 32'h0000_5000);
    tick();
    checkOutput("z_mem_req",  32'(mem_req), 32'h1);
    checkOutput("z_mem_addr", 32'(mem_addr), 32'h01014);
    checkOutput("z_no_wr_yet", 32'(tlb_write), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h8000_0033;
    tick();
    checkOutput("z_tlb_write", 32'(tlb_write), 32'h1);
    checkOutput("z_ppn",       32'(physical_page_num_mem), 32'h33);
    checkOutput("z_req_drop",  32'(mem_req), 32'h0);
    mem_ready = 1'b0; tlb_miss = 1'b0;
    tick();
    checkOutput("z_settle_wr", 32'(tlb_write), 32'h0);
    tick();
    checkOutput("z_idle_stall", 32'(itlb_stall), 32'h0);

    // Invalid PTE, fault held 5 cycles
    applyStimulus(20'h01000, 32'h00FF_0101);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0022;
    tick();
    mem_ready = 1'b0;
    checkOutput("f_fault",   32'(page_fault), 32'h1);
    checkOutput("f_fvaddr",  fault_vaddr, 32'h00FF_0101);
    checkOutput("f_no_wr",   32'(tlb_write), 32'h0);
    checkOutput("f_ppn_keep", 32'(physical_page_num_mem), 32'h33);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("f_fault_hold", 32'(page_fault), 32'h1);
      checkOutput("f_hold_no_wr", 32'(tlb_write), 32'h0);
      checkOutput("f_hold_req",   32'(mem_req), 32'h0);
    end
    fault_ack = 1'b1; tlb_miss = 1'b0; virtual_addr = 32'h0000_8000;
    tick();
    fault_ack = 1'b0;
    checkOutput("f_cleared",  32'(page_fault), 32'h0);
    checkOutput("f_idle_stall", 32'(itlb_stall), 32'h0);

    // Fault with immediate ack lasts one cycle
    applyStimulus(20'h01000, 32'h00FF_0202);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0000;
    tick();
    mem_ready = 1'b0;
    checkOutput("fi_fault",  32'(page_fault), 32'h1);
    checkOutput("fi_fvaddr", fault_vaddr, 32'h00FF_0202);
    fault_ack = 1'b1; tlb_miss = 1'b0;
    tick();
    fault_ack = 1'b0;
    checkOutput("fi_fault_drop", 32'(page_fault), 32'h0);

    // Address wrap
    applyStimulus(20'hFFFFC, 32'h0000_1ABC);
    tick();
    checkOutput("w_mem_addr", 32'(mem_addr), 32'h00000);
    mem_ready = 1'b1; mem_rdata = 32'h8000_0044;
    tick();
    checkOutput("w_ppn", 32'(physical_page_num_mem), 32'h44);
    mem_ready = 1'b0; tlb_miss = 1'b0;
    tick(); tick();

    // Reset mid-walk, late response discarded
    applyStimulus(20'h01000, 32'h0021_0101);
    tick();
    checkOutput("r_mem_req", 32'(mem_req), 32'h1);
    reset = 1'b1; tlb_miss = 1'b0;
    tick();
    checkOutput("r_req_drop",  32'(mem_req), 32'h0);
    checkOutput("r_addr_clr",  32'(mem_addr), 32'h0);
    checkOutput("r_ppn_clr",   32'(physical_page_num_mem), 32'h0);
    reset = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h8000_0055;
    tick();
    checkOutput("r_late_wr",  32'(tlb_write), 32'h0);
    checkOutput("r_late_ppn", 32'(physical_page_num_mem), 32'h0);
    mem_ready = 1'b0;
    tick();
    checkOutput("r_idle_stall", 32'(itlb_stall), 32'h0);

    // Reset wins over simultaneous mem_ready
    applyStimulus(20'h01000, 32'h0021_0101);
    tick();
    reset = 1'b1; tlb_miss = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h8000_0066;
    tick();
    checkOutput("rs_no_wr",  32'(tlb_write), 32'h0);
    checkOutput("rs_req",    32'(mem_req), 32'h0);
    checkOutput("rs_ppn",    32'(physical_page_num_mem), 32'h0);
    reset = 1'b0; mem_ready = 1'b0;
    tick();
    checkOutput("rs_after_wr", 32'(tlb_write), 32'h0);

    // Stale miss through SETTLE and VirtualAddr change during REQ
    applyStimulus(20'h02000, 32'h0000_3000);
    tick();
    checkOutput("s_mem_addr", 32'(mem_addr), 32'h0200C);
    virtual_addr = 32'h0040_0000;
    tick();
    checkOutput("s_addr_kept", 32'(mem_addr), 32'h0200C);
    mem_ready = 1'b1; mem_rdata = 32'h8000_0077;
    tick();
    mem_ready = 1'b0;
    checkOutput("s_tlb_write", 32'(tlb_write), 32'h1);
    checkOutput("s_ppn",       32'(physical_page_num_mem), 32'h77);
    tick();
    checkOutput("s_settle_wr",  32'(tlb_write), 32'h0);
    checkOutput("s_settle_req", 32'(mem_req), 32'h0);
    tick();
    checkOutput("s_idle_req",   32'(mem_req), 32'h0);
    checkOutput("s_idle_wr",    32'(tlb_write), 32'h0);
    checkOutput("s_idle_stall", 32'(itlb_stall), 32'h1);
    tick();
    checkOutput("s_walk2_req",  32'(mem_req), 32'h1);
    checkOutput("s_walk2_addr", 32'(mem_addr), 32'h03000);
    mem_ready = 1'b1; mem_rdata = 32'h8000_0088;
    tick();
    checkOutput("s_walk2_ppn", 32'(physical_page_num_mem), 32'h88);
    mem_ready = 1'b0; tlb_miss = 1'b0;
    tick(); tick();
    checkOutput("s_final_stall", 32'(itlb_stall), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
